// File: rtl/avmm_stream_bridge_if.sv
// avalon_mm_if: Avalon-MM register bus between one master and one slave.
//   address[3:0]    word address (master -> slave)
//   write           write strobe (master -> slave)
//   writedata[31:0] write data (master -> slave)
//   read            read strobe (master -> slave)
//   waitrequest     slave stall; master holds address/writedata while high
//   readdata[31:0]  read response data (slave -> master)
//   readdatavalid   one-cycle pulse qualifying readdata (slave -> master)
interface avalon_mm_if;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, write, writedata, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avmm_stream_bridge.sv
// avmm_stream_bridge: Avalon-MM slave that pushes words written to DATA into
// a show-ahead FIFO, which drains to a valid/ready stream.
//   clk_i        single clock
//   rst_n_i      asynchronous active-low reset
//   csr_if       Avalon-MM slave port (DATA/STATUS/CONTROL/SCRATCH/TX_COUNT)
//   out_data_o   FIFO head word (0 while empty)
//   out_valid_o  head word valid (enable & !empty)
//   out_ready_i  downstream accepts the head word
// Register map: 0x0 DATA (W), 0x1 STATUS (RO), 0x2 CONTROL (RW),
// 0x3 SCRATCH (RW), 0x4 TX_COUNT (RO), 0x5..0xF read 0 / writes ignored.
module avmm_stream_bridge #(
  parameter int FIFO_DEPTH   = 16,
  parameter bit RESET_ENABLE = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  avalon_mm_if.slave  csr_if,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0] DEPTH_C = 9'(FIFO_DEPTH);

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [8:0]    r_count;
  logic          r_enable;
  logic [31:0]   r_scratch;
  logic [31:0]   r_tx_count;
  logic [31:0]   r_rdata;
  logic          r_rdvalid;

  logic          w_full;
  logic          w_empty;
  logic          w_data_wr;
  logic          w_push;
  logic          w_pop;
  logic          w_ctrl_wr;
  logic          w_flush;
  logic          w_rd_acc;
  logic [31:0]   w_rd_mux;

  // full/empty come from the registered count only, so waitrequest never
  // depends combinationally on out_ready_i.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == 9'd0);

  assign w_data_wr = csr_if.write & (csr_if.address == 4'h0);
  assign w_push    = w_data_wr & ~w_full;
  assign w_ctrl_wr = csr_if.write & (csr_if.address == 4'h2);
  assign w_flush   = w_ctrl_wr & csr_if.writedata[1];
  // A read issued together with a write is dropped.
  assign w_rd_acc  = csr_if.read & ~csr_if.write;

  assign csr_if.waitrequest   = w_data_wr & w_full;
  assign csr_if.readdata      = r_rdata;
  assign csr_if.readdatavalid = r_rdvalid;

  assign out_valid_o = r_enable & ~w_empty;
  assign w_pop       = out_valid_o & out_ready_i;
  // Memory is not reset; masking on empty keeps the output at 0 after reset.
  assign out_data_o  = w_empty ? 32'd0 : r_mem[r_rptr];

  always_comb begin
    w_rd_mux = 32'd0;
    case (csr_if.address)
      4'h1:    w_rd_mux = {14'd0, w_full, w_empty, 7'd0, r_count};
      4'h2:    w_rd_mux = {31'd0, r_enable};
      4'h3:    w_rd_mux = r_scratch;
      4'h4:    w_rd_mux = r_tx_count;
      default: w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= csr_if.writedata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 9'd0;
      r_enable   <= RESET_ENABLE;
      r_scratch  <= 32'd0;
      r_tx_count <= 32'd0;
      r_rdata    <= 32'd0;
      r_rdvalid  <= 1'b0;
    end else begin
      // Flush wins over any pop in the same cycle; a flush cycle never
      // carries a push because the bus is busy with the CONTROL write.
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= 9'd0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 9'd1;
          2'b01:   r_count <= r_count - 9'd1;
          default: r_count <= r_count;
        endcase
      end

      if (w_pop) r_tx_count <= r_tx_count + 32'd1;

      if (w_ctrl_wr) r_enable <= csr_if.writedata[0];
      if (csr_if.write && (csr_if.address == 4'h3)) r_scratch <= csr_if.writedata;

      // Read response: one-cycle pulse, data forced to 0 when idle.
      r_rdvalid <= w_rd_acc;
      r_rdata   <= w_rd_acc ? w_rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_avmm_stream_bridge.sv
// Scoreboard bench for avmm_stream_bridge: read responses and stream words
// are queued when issued and checked by an independent negedge monitor.
module tb_avmm_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  avalon_mm_if bus ();

  avmm_stream_bridge #(.FIFO_DEPTH(16), .RESET_ENABLE(1'b0)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .csr_if      (bus),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready)
  );

  typedef struct {
    logic [31:0] d;
    int          due;
  } rd_exp_t;

  rd_exp_t     rdq[$];
  logic [31:0] sq[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents a response/word.
  initial forever begin
    rd_exp_t     e;
    logic [31:0] w;
    @(negedge clk);
    if (rst_n) begin
      if (bus.readdatavalid) begin
        if (rdq.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: readdatavalid=1 readdata=%h with no read outstanding", bus.readdata);
        end else begin
          e = rdq.pop_front();
          chk("rd_data", bus.readdata, e.d);
          chk("rd_latency", 32'(cyc), 32'(e.due));
        end
      end
      if (out_valid && out_ready) begin
        if (sq.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: word %h popped with none expected", out_data);
        end else begin
          w = sq.pop_front();
          chk("out_data", out_data, w);
        end
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input bit expect_out);
    int n;
    n = 0;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    forever begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      n++;
      if (n >= 60) begin
        n_checks++;
        $display("FAIL wr_timeout: waitrequest still 1 after %0d cycles, required 0", n);
        @(posedge clk); #1;
        bus.write = 1'b0;
        return;
      end
    end
    @(posedge clk);
    if (expect_out && a == 4'h0) sq.push_back(d);
    #1;
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input bit expect_resp);
    rd_exp_t e;
    bus.address = a; bus.read = 1'b1;
    if (expect_resp) begin
      e.d = exp; e.due = cyc + 1;
      rdq.push_back(e);
    end
    @(posedge clk); #1;
    bus.read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(sq.size()), 32'd0);
  endtask

  initial begin
    int stall;
    rst_n = 1'b0;
    bus.address = 4'h0; bus.write = 1'b0; bus.writedata = 32'd0; bus.read = 1'b0;
    out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitrequest", {31'd0, bus.waitrequest}, 32'd0);
    chk("rst_rdvalid", {31'd0, bus.readdatavalid}, 32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    idle(1);
    bus_read(4'h1, 32'h0001_0000, 1'b1);
    bus_read(4'h2, 32'h0000_0000, 1'b1);
    bus_read(4'h4, 32'h0000_0000, 1'b1);
    idle(1);
    chk("rdata_idle_zero", bus.readdata, 32'd0);

    // Ordering
    out_ready = 1'b1;
    bus_write(4'h2, 32'd1, 1'b0);
    bus.address = 4'h0; bus.writedata = 32'hA5A5_0001; bus.write = 1'b1;
    @(negedge clk);
    chk("ord_no_wait", {31'd0, bus.waitrequest}, 32'd0);
    chk("ord_no_bypass", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    sq.push_back(32'hA5A5_0001);
    #1;
    bus.write = 1'b0;
    chk("ord_vis_valid", {31'd0, out_valid}, 32'd1);
    chk("ord_vis_data", out_data, 32'hA5A5_0001);
    for (int i = 2; i <= 4; i++) begin
      bus_write(4'h0, 32'hA5A5_0000 + 32'(i), 1'b1);
      chk("ord_vis_valid", {31'd0, out_valid}, 32'd1);
      chk("ord_vis_data", out_data, 32'hA5A5_0000 + 32'(i));
    end
    drain();
    bus_read(4'h4, 32'd4, 1'b1);
    idle(1);

    // Backpressure
    out_ready = 1'b0;
    bus_write(4'h2, 32'd0, 1'b0);
    for (int i = 0; i < 16; i++) bus_write(4'h0, 32'hB000_0000 + 32'(i), 1'b1);
    bus_read(4'h1, 32'h0002_0010, 1'b1);
    bus.address = 4'h0; bus.writedata = 32'hB000_0010; bus.write = 1'b1;
    stall = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.waitrequest) stall++;
      @(posedge clk); #1;
    end
    chk("bp_stall_cycles", 32'(stall), 32'd10);
    // A second master wins arbitration for one cycle to enable the stream.
    bus.address = 4'h2; bus.writedata = 32'd1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ctrl_no_wait", {31'd0, bus.waitrequest}, 32'd0);
    @(posedge clk); #1;
    bus.address = 4'h0; bus.writedata = 32'hB000_0010;
    @(negedge clk);
    chk("bp_full_before_pop", {31'd0, bus.waitrequest}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_accept_after_pop", {31'd0, bus.waitrequest}, 32'd0);
    @(posedge clk);
    sq.push_back(32'hB000_0010);
    #1;
    bus.write = 1'b0;
    drain();

    // Flush
    out_ready = 1'b0;
    bus_write(4'h2, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) bus_write(4'h0, 32'hC000_0000 + 32'(i), 1'b0);
    bus_read(4'h1, 32'h0000_0005, 1'b1);
    bus_write(4'h2, 32'h2, 1'b0);
    bus_read(4'h1, 32'h0001_0000, 1'b1);
    bus_read(4'h2, 32'h0000_0000, 1'b1);
    out_ready = 1'b1;
    bus_write(4'h2, 32'd1, 1'b0);
    bus_write(4'h0, 32'hD000_0001, 1'b1);
    bus_write(4'h0, 32'hD000_0002, 1'b1);
    drain();

    // Registers, unmapped space, read+write collision
    bus_write(4'h3, 32'hDEAD_BEEF, 1'b0);
    bus_read(4'h3, 32'hDEAD_BEEF, 1'b1);
    bus_read(4'hF, 32'd0, 1'b1);
    bus_read(4'h0, 32'd0, 1'b1);
    bus.address = 4'h3; bus.writedata = 32'h1234_5678; bus.write = 1'b1; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.write = 1'b0; bus.read = 1'b0;
    @(negedge clk);
    chk("rw_no_rdvalid", {31'd0, bus.readdatavalid}, 32'd0);
    @(posedge clk); #1;
    bus_read(4'h3, 32'h1234_5678, 1'b1);
    bus_write(4'h7, 32'hFFFF_FFFF, 1'b0);
    bus_read(4'h7, 32'd0, 1'b1);
    bus_read(4'h4, 32'd23, 1'b1);

    // TX_COUNT wrap
    force dut.r_tx_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_tx_count;
    @(posedge clk); #1;
    bus_read(4'h4, 32'hFFFF_FFFF, 1'b1);
    bus_write(4'h0, 32'hE000_0001, 1'b1);
    idle(2);
    bus_read(4'h4, 32'd0, 1'b1);
    idle(1);

    // Async reset during a read response
    bus.address = 4'h1; bus.read = 1'b1;
    @(posedge clk); #2;
    bus.read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_rdvalid", {31'd0, bus.readdatavalid}, 32'd0);
    chk("arst_rd_readdata", bus.readdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_late_rdvalid", {31'd0, bus.readdatavalid}, 32'd0);
    end
    @(posedge clk); #1;

    // Async reset during a stalled write
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(4'h0, 32'hF000_0000 + 32'(i), 1'b0);
    bus.address = 4'h0; bus.writedata = 32'hF000_0010; bus.write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("arst_stall_pre", {31'd0, bus.waitrequest}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stall_wait", {31'd0, bus.waitrequest}, 32'd0);
    chk("arst_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_stall_data", out_data, 32'd0);
    bus.write = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus_read(4'h1, 32'h0001_0000, 1'b1);
    bus_read(4'h2, 32'h0000_0000, 1'b1);
    idle(2);
    chk("final_rdq_empty", 32'(rdq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avmm_stream_bridge.md
Name: avmm_stream_bridge

Overview:
- Avalon-MM slave that consumes transactions from an avalon_mm_if master through the slave modport.
- Bus writes to the DATA register push 32-bit words into an internal FIFO. The FIFO drains to a downstream valid/ready stream.
- Control, status, scratch and counter registers sit alongside DATA in the 16-word address space.
- Waitrequest backpressures the bus master when the FIFO is full.

Parameters:
- FIFO_DEPTH, 16: FIFO entries; power of two, range 2..256.
- RESET_ENABLE, 0: reset value of CONTROL.enable.

Ports:
- clk_i  input  1  single clock for all logic.
- rst_n_i  input  1  asynchronous, active-low reset.
- csr_if  interface  avalon_mm_if.slave
  - address[3:0], write, writedata[31:0] and read are inputs.
  - waitrequest, readdata[31:0] and readdatavalid are outputs.
- out_data_o  output  32  FIFO head word.
- out_valid_o  output  1  head word valid.
- out_ready_i  input  1  downstream accepts the word.

Behaviour:
- Reset: one clock domain. rst_n_i is asynchronous and active-low, deasserted synchronously by the system. While rst_n_i=0:
  - waitrequest=0, readdata=0, readdatavalid=0.
  - out_valid_o=0, out_data_o=0.
  - FIFO empty; TX_COUNT=0; SCRATCH=0.
  - CONTROL.enable=RESET_ENABLE; CONTROL.flush=0.
- Reset mid-operation discards all FIFO contents, a pending stalled write and any in-flight read response.
- Address map (word addresses):
  - 0x0 DATA, W. Push writedata. Reads return 0.
  - 0x1 STATUS, RO:
    - [8:0] used word count, 0..FIFO_DEPTH.
    - [16] empty.
    - [17] full.
    - others 0.
  - 0x2 CONTROL, RW:
    - [0] enable.
    - [1] flush: write-1, self-clearing, always reads 0.
  - 0x3 SCRATCH, RW, 32 bits.
  - 0x4 TX_COUNT, RO: words popped downstream, 32-bit, wraps 0xFFFFFFFF->0.
  - 0x5..0xF: reads return 0, writes ignored, no stall.
- Waitrequest: combinational, waitrequest = write & (address==0) & full. full is the registered flag, with no combinational path from out_ready_i.
  - A write is accepted in the cycle write=1 and waitrequest=0.
  - A stalled master holds address and writedata. The write completes in the first cycle full=0.
- Reads:
  - Never stalled.
  - A read accepted in cycle N gives readdatavalid=1 and readdata in cycle N+1; fixed latency 1.
  - readdatavalid is a single-cycle pulse per read. readdata returns to 0 when readdatavalid=0.
  - Back-to-back reads produce back-to-back responses.
  - Read data reflects register state sampled in cycle N, before that cycle's updates.
- read and write both high: illegal. The write is performed, the read is ignored and no readdatavalid is produced.
- FIFO:
  - Show-ahead. out_data_o = head word.
  - out_valid_o = enable & !empty.
  - Pop occurs when out_valid_o & out_ready_i; TX_COUNT increments on each pop.
  - A pushed word becomes visible at the head, or out_valid_o rises, the cycle after acceptance. There is no same-cycle bypass.
  - Simultaneous push and pop (not full) leaves the count unchanged.
  - While full, a pop frees a slot; the stalled write is accepted the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- enable=0 holds out_valid_o low and pops nothing. Pushes are still accepted until full.
- Flush:
  - A write to CONTROL with bit1=1 empties the FIFO at the end of that cycle.
  - A pop in the flush cycle still counts in TX_COUNT.
  - The enable bit written in the same access takes effect normally.
  - TX_COUNT is not cleared by flush.
- No stall-timeout logic: a stall persists while full and enable=0.

Test Plan:
- Reset value:
  - Stimulus: reset release, then read 0x1, 0x2, 0x4.
  - Required: readdatavalid exactly 1 cycle after each read; data 0x00010000, 0x00000000 (RESET_ENABLE=0), 0x00000000.
- Ordering:
  - Stimulus: write 0x2=1, write DATA 0xA5A50001..0xA5A50004 with out_ready_i=1.
  - Required: out_data_o sequence 0xA5A50001..0xA5A50004, each valid one cycle after acceptance; TX_COUNT reads 4.
- Backpressure:
  - Stimulus: enable=0, write 16 words; STATUS reads 0x00020010. A 17th write is held with waitrequest=1 for 10 cycles. Then set out_ready_i=1 and enable=1 via a CONTROL write, issued from a second master or the bench.
  - Required: the 17th write is accepted the cycle after the first pop; the word order is preserved.
- Flush:
  - Stimulus: 5 words queued, enable=0, write CONTROL=0x2.
  - Required: next-cycle STATUS=0x00010000; CONTROL reads 0; subsequent pushes are output normally.
- Register and wrap checks:
  - Stimulus: write SCRATCH 0xDEADBEEF, read back; read 0xF; issue read+write together.
  - Required: 0xDEADBEEF returned; 0 returned for 0xF; the combined read+write gives no readdatavalid and the write takes effect.
  - TX_COUNT wrap is covered by a forced counter value 0xFFFFFFFF followed by one pop, which must read 0.
- Async reset:
  - Stimulus: assert rst_n_i mid-stall and mid-read, off a clock edge.
  - Required: all outputs go to reset values immediately; no readdatavalid after release.
